// File: rtl/tree_scene_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// tree_scene_pkg
// Shared types and constants for the Christmas tree scene sequencer:
//   - scene_t       : scene state machine encoding (also driven on the debug port)
//   - DEF_LINE*_LEN : default text line lengths
//   - STAR_*        : colour indices of the star palette
//   - param_in_range: elaboration-time range check for sequencer parameters
// -----------------------------------------------------------------------------
package tree_scene_pkg;

  typedef enum logic [2:0] {
    S_INTRO   = 3'd0,
    S_REVEAL1 = 3'd1,
    S_REVEAL2 = 3'd2,
    S_HOLD    = 3'd3,
    S_BLANK   = 3'd4
  } scene_t;

  localparam int DEF_LINE1_LEN = 32'd10;
  localparam int DEF_LINE2_LEN = 32'd18;

  // Largest value any frame/length parameter may take (8-bit counters).
  localparam int PARAM_MAX = 32'd255;

  localparam logic [1:0] STAR_DARK_RED = 2'b00;
  localparam logic [1:0] STAR_RED      = 2'b01;
  localparam logic [1:0] STAR_YELLOW   = 2'b10;
  localparam logic [1:0] STAR_ORANGE   = 2'b11;

  // True when a parameter is usable: at least one and no larger than max_value.
  function automatic bit param_in_range(input int value, input int max_value);
    return (value >= 32'sd1) && (value <= max_value);
  endfunction

endpackage

// File: rtl/tree_scene_sequencer_frame_divider.sv
// -----------------------------------------------------------------------------
// frame_divider
// Counts input ticks 0..DIV-1 and pulses wrap on the tick that completes a
// full cycle, so DIV ticks produce exactly one wrap.
//   clk   : pixel clock
//   reset : synchronous, active-high
//   tick  : one-cycle event to count (frame start)
//   wrap  : combinational pulse, coincident with the DIV-th tick
// -----------------------------------------------------------------------------
module frame_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  output logic wrap
);

  logic [7:0] cnt_r;
  logic       last_s;

  assign last_s = (cnt_r == (8'(DIV) - 8'd1));
  assign wrap   = tick && last_s;

  // Tick counter: clears on wrap so the period is exactly DIV ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= 8'd0;
    end else if (wrap) begin
      cnt_r <= 8'd0;
    end else if (tick) begin
      cnt_r <= cnt_r + 8'd1;
    end
  end

endmodule

// File: rtl/tree_scene_sequencer.sv
// -----------------------------------------------------------------------------
// tree_scene_sequencer
// Frame-rate scene controller for the Christmas tree display. Detects frame
// starts on vsync and loops INTRO -> REVEAL1 -> REVEAL2 -> HOLD -> BLANK,
// revealing the two text lines one character at a time. Also steps the star
// colour and the garland light phase every STAR_FRAMES / LIGHT_FRAMES frames.
// Ports:
//   clk, reset       : pixel clock, synchronous active-high reset
//   vsync            : vertical sync from the timing generator
//   pause, step      : freeze the scene; step advances it by one frame while paused
//   show_tree        : tree body/trunk/star enable
//   line1_count      : characters of line 1 visible (index i drawn iff i < count)
//   line2_count      : characters of line 2 visible
//   star_color       : star palette index
//   light_phase      : garland stripe phase
//   frame_tick       : one-cycle pulse per frame start
//   scene            : current scene encoding (debug)
// All outputs are registered and update the cycle after the frame start,
// i.e. during vertical sync.
// -----------------------------------------------------------------------------
module tree_scene_sequencer
  import tree_scene_pkg::*;
#(
  parameter int FRAMES_PER_CHAR = 8,
  parameter int INTRO_FRAMES    = 60,
  parameter int HOLD_FRAMES     = 240,
  parameter int BLANK_FRAMES    = 30,
  parameter int STAR_FRAMES     = 64,
  parameter int LIGHT_FRAMES    = 8,
  parameter int LINE1_LEN       = DEF_LINE1_LEN,
  parameter int LINE2_LEN       = DEF_LINE2_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       pause,
  input  logic       step,
  output logic       show_tree,
  output logic [3:0] line1_count,
  output logic [4:0] line2_count,
  output logic [1:0] star_color,
  output logic [1:0] light_phase,
  output logic       frame_tick,
  output logic [2:0] scene
);

  // Line lengths must also fit the count ports.
  if (!(param_in_range(FRAMES_PER_CHAR, PARAM_MAX) && param_in_range(INTRO_FRAMES, PARAM_MAX) &&
        param_in_range(HOLD_FRAMES, PARAM_MAX)     && param_in_range(BLANK_FRAMES, PARAM_MAX) &&
        param_in_range(STAR_FRAMES, PARAM_MAX)     && param_in_range(LIGHT_FRAMES, PARAM_MAX) &&
        param_in_range(LINE1_LEN, 32'd15)          && param_in_range(LINE2_LEN, 32'd31))) begin : g_bad_params
    $error("tree_scene_sequencer: a parameter is zero or too wide");
  end

  localparam logic [7:0] INTRO_LAST = 8'(INTRO_FRAMES) - 8'd1;
  localparam logic [7:0] CHAR_LAST  = 8'(FRAMES_PER_CHAR) - 8'd1;
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES) - 8'd1;
  localparam logic [7:0] BLANK_LAST = 8'(BLANK_FRAMES) - 8'd1;
  localparam logic [3:0] L1_FULL    = 4'(LINE1_LEN);
  localparam logic [4:0] L2_FULL    = 5'(LINE2_LEN);

  logic       vsync_q_r;
  logic       armed_r;
  logic       frame_start_s;
  logic       adv_s;
  logic       star_wrap_s;
  logic       light_wrap_s;

  scene_t     scene_r;
  scene_t     scene_next_s;
  logic [7:0] fcnt_r;
  logic [7:0] fcnt_next_s;
  logic [3:0] line1_r;
  logic [3:0] line1_next_s;
  logic [4:0] line2_r;
  logic [4:0] line2_next_s;
  logic       show_tree_r;
  logic       frame_tick_r;
  logic [1:0] star_color_r;
  logic [1:0] light_phase_r;

  // armed_r blocks the edge detector until vsync has been seen low after
  // reset, so a vsync already high at reset release is not a frame start.
  assign frame_start_s = vsync && !vsync_q_r && armed_r;

  // A paused scene moves only on step; frame starts are then dropped, and a
  // coincident step plus frame start is a single advance.
  assign adv_s = pause ? step : frame_start_s;

  frame_divider #(.DIV(STAR_FRAMES)) u_star_div (
    .clk   (clk),
    .reset (reset),
    .tick  (frame_start_s),
    .wrap  (star_wrap_s)
  );

  frame_divider #(.DIV(LIGHT_FRAMES)) u_light_div (
    .clk   (clk),
    .reset (reset),
    .tick  (frame_start_s),
    .wrap  (light_wrap_s)
  );

  // vsync edge detector and post-reset arming.
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q_r <= 1'b0;
      armed_r   <= ~vsync;
    end else begin
      vsync_q_r <= vsync;
      if (!vsync) begin
        armed_r <= 1'b1;
      end
    end
  end

  // Scene next-state, frame counter and character count logic.
  always_comb begin
    scene_next_s = scene_r;
    fcnt_next_s  = fcnt_r;
    line1_next_s = line1_r;
    line2_next_s = line2_r;
    if (adv_s) begin
      case (scene_r)
        S_INTRO: begin
          if (fcnt_r == INTRO_LAST) begin
            scene_next_s = S_REVEAL1;
            fcnt_next_s  = 8'd0;
          end else begin
            fcnt_next_s = fcnt_r + 8'd1;
          end
        end
        S_REVEAL1: begin
          if (fcnt_r == CHAR_LAST) begin
            fcnt_next_s = 8'd0;
            // Saturating increment; the last character moves on at once.
            if (line1_r >= (L1_FULL - 4'd1)) begin
              line1_next_s = L1_FULL;
              scene_next_s = S_REVEAL2;
            end else begin
              line1_next_s = line1_r + 4'd1;
            end
          end else begin
            fcnt_next_s = fcnt_r + 8'd1;
          end
        end
        S_REVEAL2: begin
          line1_next_s = L1_FULL;
          if (fcnt_r == CHAR_LAST) begin
            fcnt_next_s = 8'd0;
            if (line2_r >= (L2_FULL - 5'd1)) begin
              line2_next_s = L2_FULL;
              scene_next_s = S_HOLD;
            end else begin
              line2_next_s = line2_r + 5'd1;
            end
          end else begin
            fcnt_next_s = fcnt_r + 8'd1;
          end
        end
        S_HOLD: begin
          if (fcnt_r == HOLD_LAST) begin
            scene_next_s = S_BLANK;
            fcnt_next_s  = 8'd0;
            line1_next_s = 4'd0;
            line2_next_s = 5'd0;
          end else begin
            fcnt_next_s = fcnt_r + 8'd1;
          end
        end
        S_BLANK: begin
          if (fcnt_r == BLANK_LAST) begin
            scene_next_s = S_INTRO;
            fcnt_next_s  = 8'd0;
          end else begin
            fcnt_next_s = fcnt_r + 8'd1;
          end
        end
        default: begin
          scene_next_s = S_INTRO;
          fcnt_next_s  = 8'd0;
          line1_next_s = 4'd0;
          line2_next_s = 5'd0;
        end
      endcase
    end else begin
      scene_next_s = scene_r;
    end
  end

  // Scene state register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      scene_r       <= S_INTRO;
      fcnt_r        <= 8'd0;
      line1_r       <= 4'd0;
      line2_r       <= 5'd0;
      show_tree_r   <= 1'b1;
      frame_tick_r  <= 1'b0;
      star_color_r  <= STAR_DARK_RED;
      light_phase_r <= 2'd0;
    end else begin
      scene_r      <= scene_next_s;
      fcnt_r       <= fcnt_next_s;
      line1_r      <= line1_next_s;
      line2_r      <= line2_next_s;
      show_tree_r  <= (scene_next_s != S_BLANK);
      frame_tick_r <= frame_start_s;
      if (star_wrap_s) begin
        star_color_r <= star_color_r + 2'd1;
      end
      if (light_wrap_s) begin
        light_phase_r <= light_phase_r + 2'd1;
      end
    end
  end

  assign show_tree   = show_tree_r;
  assign line1_count = line1_r;
  assign line2_count = line2_r;
  assign star_color  = star_color_r;
  assign light_phase = light_phase_r;
  assign frame_tick  = frame_tick_r;
  assign scene       = scene_r;

endmodule

// File: tb/tb_tree_scene_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tree_scene_sequencer
// Directed bench for tree_scene_sequencer with short scene parameters: a
// table of per-frame expectations for a 30-frame run, then hand-written
// sequences for pause/step, coincident step and frame start, and mid-scene
// reset. Star and light phases are predicted from the number of frames sent.
// -----------------------------------------------------------------------------
module tb_tree_scene_sequencer;
  import tree_scene_pkg::*;

  localparam int FPC   = 2;
  localparam int INTRO = 2;
  localparam int HOLD  = 3;
  localparam int BLANK = 2;
  localparam int STAR  = 4;
  localparam int LIGHT = 2;
  localparam int L1    = 3;
  localparam int L2    = 2;

  logic       clk;
  logic       reset;
  logic       vsync;
  logic       pause;
  logic       step;
  logic       show_tree;
  logic [3:0] line1_count;
  logic [4:0] line2_count;
  logic [1:0] star_color;
  logic [1:0] light_phase;
  logic       frame_tick;
  logic [2:0] scene;

  int n_vec;
  int n_err;
  int frames;

  typedef struct {
    logic       vs;
    logic       st;
    logic [2:0] sc;
    logic [3:0] l1;
    logic [4:0] l2;
    logic       sh;
  } vec_t;

  vec_t tbl[30];

  tree_scene_sequencer #(
    .FRAMES_PER_CHAR (FPC),
    .INTRO_FRAMES    (INTRO),
    .HOLD_FRAMES     (HOLD),
    .BLANK_FRAMES    (BLANK),
    .STAR_FRAMES     (STAR),
    .LIGHT_FRAMES    (LIGHT),
    .LINE1_LEN       (L1),
    .LINE2_LEN       (L2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .vsync       (vsync),
    .pause       (pause),
    .step        (step),
    .show_tree   (show_tree),
    .line1_count (line1_count),
    .line2_count (line2_count),
    .star_color  (star_color),
    .light_phase (light_phase),
    .frame_tick  (frame_tick),
    .scene       (scene)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input scene_t sc, input int l1, input int l2, input logic sh);
    vec_t v;
    v.vs = 1'b1;
    v.st = 1'b0;
    v.sc = sc;
    v.l1 = 4'(l1);
    v.l2 = 5'(l2);
    v.sh = sh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Star/light expectations come from the frame count since the last reset.
  task automatic chk_all(input string nm, input logic [2:0] sc, input int l1, input int l2,
                         input logic sh, input logic ft);
    chk({nm, ".scene"}, 32'(scene), 32'(sc));
    chk({nm, ".line1"}, 32'(line1_count), 32'(l1));
    chk({nm, ".line2"}, 32'(line2_count), 32'(l2));
    chk({nm, ".show_tree"}, 32'(show_tree), 32'(sh));
    chk({nm, ".frame_tick"}, 32'(frame_tick), 32'(ft));
    chk({nm, ".star"}, 32'(star_color), 32'((frames / STAR) % 4));
    chk({nm, ".light"}, 32'(light_phase), 32'((frames / LIGHT) % 4));
  endtask

  // One event cycle; returns at the negedge where its result is visible.
  task automatic pulse(input logic vs, input logic st);
    @(negedge clk);
    vsync = vs;
    step  = st;
    @(negedge clk);
    vsync = 1'b0;
    step  = 1'b0;
    if (vs) frames++;
  endtask

  task automatic idle();
    @(negedge clk);
    chk("tick_one_cycle", 32'(frame_tick), 32'd0);
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    frames = 0;
    reset  = 1'b1;
    vsync  = 1'b1;
    pause  = 1'b0;
    step   = 1'b0;

    // Hand-computed scene after each frame (period of 17 frames).
    tbl[0]  = mk(S_INTRO,   0, 0, 1'b1);
    tbl[1]  = mk(S_REVEAL1, 0, 0, 1'b1);
    tbl[2]  = mk(S_REVEAL1, 0, 0, 1'b1);
    tbl[3]  = mk(S_REVEAL1, 1, 0, 1'b1);
    tbl[4]  = mk(S_REVEAL1, 1, 0, 1'b1);
    tbl[5]  = mk(S_REVEAL1, 2, 0, 1'b1);
    tbl[6]  = mk(S_REVEAL1, 2, 0, 1'b1);
    tbl[7]  = mk(S_REVEAL2, 3, 0, 1'b1);
    tbl[8]  = mk(S_REVEAL2, 3, 0, 1'b1);
    tbl[9]  = mk(S_REVEAL2, 3, 1, 1'b1);
    tbl[10] = mk(S_REVEAL2, 3, 1, 1'b1);
    tbl[11] = mk(S_HOLD,    3, 2, 1'b1);
    tbl[12] = mk(S_HOLD,    3, 2, 1'b1);
    tbl[13] = mk(S_HOLD,    3, 2, 1'b1);
    tbl[14] = mk(S_BLANK,   0, 0, 1'b0);
    tbl[15] = mk(S_BLANK,   0, 0, 1'b0);
    tbl[16] = mk(S_INTRO,   0, 0, 1'b1);
    tbl[17] = mk(S_INTRO,   0, 0, 1'b1);
    tbl[18] = mk(S_REVEAL1, 0, 0, 1'b1);
    tbl[19] = mk(S_REVEAL1, 0, 0, 1'b1);
    tbl[20] = mk(S_REVEAL1, 1, 0, 1'b1);
    tbl[21] = mk(S_REVEAL1, 1, 0, 1'b1);
    tbl[22] = mk(S_REVEAL1, 2, 0, 1'b1);
    tbl[23] = mk(S_REVEAL1, 2, 0, 1'b1);
    tbl[24] = mk(S_REVEAL2, 3, 0, 1'b1);
    tbl[25] = mk(S_REVEAL2, 3, 0, 1'b1);
    tbl[26] = mk(S_REVEAL2, 3, 1, 1'b1);
    tbl[27] = mk(S_REVEAL2, 3, 1, 1'b1);
    tbl[28] = mk(S_HOLD,    3, 2, 1'b1);
    tbl[29] = mk(S_HOLD,    3, 2, 1'b1);

    // Reset values, with vsync held high through reset release.
    repeat (3) @(negedge clk);
    chk_all("reset", S_INTRO, 0, 0, 1'b1, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("vsync_high_at_release", 32'(frame_tick), 32'd0);
    end
    vsync = 1'b0;
    @(negedge clk);
    chk_all("after_release", S_INTRO, 0, 0, 1'b1, 1'b0);

    // 30-frame scene run.
    for (int i = 0; i < 30; i++) begin
      pulse(tbl[i].vs, tbl[i].st);
      chk_all($sformatf("frame%0d", i + 1), tbl[i].sc, int'(tbl[i].l1), int'(tbl[i].l2),
              tbl[i].sh, tbl[i].vs);
      idle();
    end

    // Run on to REVEAL1 with the frame counter at zero (frame 36).
    for (int i = 0; i < 6; i++) begin
      pulse(1'b1, 1'b0);
      idle();
    end
    chk_all("reveal1_start", S_REVEAL1, 0, 0, 1'b1, 1'b0);

    // Paused: scene frozen, star and lights keep going.
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pulse(1'b1, 1'b0);
      chk_all($sformatf("paused%0d", i), S_REVEAL1, 0, 0, 1'b1, 1'b1);
      idle();
    end

    // Two steps make one character.
    pulse(1'b0, 1'b1);
    chk_all("step1", S_REVEAL1, 0, 0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    chk_all("step2", S_REVEAL1, 1, 0, 1'b1, 1'b0);

    // Step together with a frame start is a single advance.
    pulse(1'b1, 1'b1);
    chk_all("step_and_frame", S_REVEAL1, 1, 0, 1'b1, 1'b1);
    idle();
    pulse(1'b0, 1'b1);
    chk_all("step_after_combo", S_REVEAL1, 2, 0, 1'b1, 1'b0);

    // Resume with no catch-up and reach REVEAL2 with line2_count = 1.
    pause = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pulse(1'b1, 1'b0);
      idle();
    end
    chk_all("reveal2_mid", S_REVEAL2, 3, 1, 1'b1, 1'b0);

    // One-cycle reset mid-reveal.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    frames = 0;
    chk_all("mid_reset", S_INTRO, 0, 0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    chk_all("restart_f1", S_INTRO, 0, 0, 1'b1, 1'b1);
    idle();
    pulse(1'b1, 1'b0);
    chk_all("restart_f2", S_REVEAL1, 0, 0, 1'b1, 1'b1);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tree_scene_sequencer.md
# tree_scene_sequencer

Frame-rate scene controller for the Christmas tree VGA display. It detects frame starts from `vsync` and runs a looping scene state machine: intro, typewriter reveal of line 1 then line 2, hold, blank. It also produces the star colour index and a scrolling phase for the garland lights. It sits between `hvsync_generator` and the pixel colour logic, which uses its registered outputs to gate text characters, the tree and the lights.

## Interface
Parameters:
- `FRAMES_PER_CHAR`, default 8: frames between successive revealed characters.
- `INTRO_FRAMES`, default 60: frames showing the tree with no text.
- `HOLD_FRAMES`, default 240: frames showing full text.
- `BLANK_FRAMES`, default 30: frames with the tree and text hidden.
- `STAR_FRAMES`, default 64: frames per star colour step.
- `LIGHT_FRAMES`, default 8: frames per garland phase step.
- `LINE1_LEN`, default 10: characters in line 1.
- `LINE2_LEN`, default 18: characters in line 2.

Ports:
- `clk` in 1: pixel clock. Single clock domain.
- `reset` in 1: synchronous, active-high.
- `vsync` in 1: vsync from `hvsync_generator`, same clock domain.
- `pause` in 1: level input. While high, the scene state machine and its counters freeze.
- `step` in 1: single-cycle pulse. While `pause` is high, it advances the scene by exactly one frame.
- `show_tree` out 1: enables the tree body, trunk and star.
- `line1_count` out 4: number of line-1 characters visible. Character index `i` is drawn iff `i < line1_count`.
- `line2_count` out 5: same rule for line 2.
- `star_color` out 2: `color_select` for the star.
- `light_phase` out 2: added to the stripe row selector by the pixel logic.
- `frame_tick` out 1: one-cycle pulse per detected frame start.
- `scene` out 3: current state encoding, for debug.

## Operation
- Edge detect: `vsync_q` registers `vsync`. A frame start is a cycle with `vsync` high and `vsync_q` low.
- Star and light counters advance on every frame start, regardless of `pause`.
  - The star divider counts 0..`STAR_FRAMES`-1. On wrap, `star_color` increments mod 4.
  - The light divider works the same way with `LIGHT_FRAMES` and drives `light_phase`.
- Scene advance event (`adv`):
  - When `pause` is low: `adv` = frame start.
  - When `pause` is high: `adv` = `step`.
  - A frame start while paused never advances the scene. Frame start and `step` in the same cycle while paused give one advance, not two.
- States (encoding: INTRO=0, REVEAL1=1, REVEAL2=2, HOLD=3, BLANK=4). `fcnt` is the frame counter; it is 8 bits wide.
  - INTRO: `show_tree`=1, both counts 0. On each `adv`, `fcnt`++. When `fcnt`=`INTRO_FRAMES`-1 on an `adv`, go to REVEAL1 with `fcnt`=0.
  - REVEAL1: on each `adv`, `fcnt`++. When `fcnt`=`FRAMES_PER_CHAR`-1, set `fcnt`=0 and `line1_count`++. When `line1_count` reaches `LINE1_LEN`, go to REVEAL2 on the same edge.
  - REVEAL2: same as REVEAL1 using `line2_count` and `LINE2_LEN`, then go to HOLD. `line1_count` stays at `LINE1_LEN`.
  - HOLD: counts are held full. After `HOLD_FRAMES` advances, go to BLANK.
  - BLANK: `show_tree`=0, both counts 0. After `BLANK_FRAMES` advances, go to INTRO.
- Counts saturate at their length. They never exceed `LINE1_LEN` or `LINE2_LEN`.
- All parameters must be at least 1 and must fit in 8 bits. This is checked by an elaboration-time assertion.

## Timing
- All outputs are registered.
- Reset values: `show_tree`=1, `line1_count`=0, `line2_count`=0, `star_color`=0, `light_phase`=0, `frame_tick`=0, `scene`=INTRO. All internal counters and `vsync_q` are 0.
- Latency: a frame start sampled in cycle N is visible on `frame_tick` and all updated outputs in cycle N+1. `frame_tick` is high for exactly one cycle.
- A `vsync` that is high during reset release does not produce a frame start until it falls and rises again.
- `reset` asserted mid-scene: every register returns to its reset value on the next edge. This holds mid-reveal and while paused.
- `pause` deasserting has no catch-up: frames missed while paused are lost.
- Output changes land during vertical sync, so a frame is never torn.

## Structure
- Package `tree_scene_pkg`:
  - `scene_t` enum with the encodings above.
  - Default line lengths.
  - Colour index constants for the star palette (00 dark red, 01 red, 10 yellow, 11 orange).
- One sub-module, `frame_divider`:
  - Parameter `DIV`. Inputs: `tick`, `reset`.
  - Output: a `wrap` pulse, where `DIV` ticks produce exactly one wrap.
  - Instantiated twice, once for the star and once for the lights.

## Test plan
- Reset, then pulse `vsync` 0→1 once → `frame_tick`=1 for one cycle at N+1, `scene`=INTRO, `show_tree`=1, counts 0.
- With `INTRO_FRAMES`=2, `FRAMES_PER_CHAR`=2, `LINE1_LEN`=3, `LINE2_LEN`=2, `HOLD_FRAMES`=3, `BLANK_FRAMES`=2, drive 30 frames. Required:
  - `line1_count` steps 1,2,3 at frames 4,6,8.
  - `line2_count` steps 1,2 at frames 10,12.
  - HOLD from frame 12 to frame 15, BLANK (`show_tree`=0) at frame 15, INTRO at frame 17.
- `pause`=1 for 10 frames mid-REVEAL1 → counts and `scene` frozen, while `star_color` and `light_phase` keep stepping. Then `step`×2 with `FRAMES_PER_CHAR`=2 → `line1_count` increments by 1.
- `step` in the same cycle as a frame start while paused → `fcnt` advances by 1 only.
- With `STAR_FRAMES`=4, drive 17 frames → `star_color` sequence 0,1,2,3,0, changing at frames 4, 8, 12 and 16.
- Assert `reset` for 1 cycle during REVEAL2 with `line2_count`=1 → next cycle all outputs at reset values, and the next frame start restarts INTRO.
